hilo_writeback: RTL and testbench

Downstream stage of the Booth multiplier in the datapath. It accepts 64-bit results over a valid/ready handshake and buffers them in a small FIFO. Each result is committed into the architectural HI/LO registers when the control unit asserts the commit strobe. It drives HI or LO onto the bus for mfhi/mflo and flags products that do not fit in a signed 32-bit value.

---
 rtl/datapath_pkg.sv | 15 +
 rtl/result_fifo.sv | 66 ++++++
 rtl/hilo_writeback.sv | 96 +++++++++
 tb/tb_hilo_writeback.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types for the multiply/divide writeback path.
// Result source encodings and the buffered result entry layout.
package datapath_pkg;

   localparam int WIDTH = 32;

   localparam logic RES_SRC_MUL = 1'b0;
   localparam logic RES_SRC_DIV = 1'b1;

   typedef struct packed {
      logic [2*WIDTH-1:0] product;
      logic               src;
   } fifo_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with explicit occupancy count.
// Pushes when full and pops when empty are ignored.
module result_fifo #(
   parameter int DEPTH = 2,
   parameter int DW    = 65
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [DW-1:0]            push_data_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap naturally
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/hilo_writeback.sv
// HI/LO writeback: buffers mul/div results and commits them on hilo_en.
// Also drives mfhi/mflo read data and the signed-overflow flag.
module hilo_writeback
   import datapath_pkg::*;
#(
   parameter int WIDTH = datapath_pkg::WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [2*WIDTH-1:0]       res_product,
   input  logic                     res_src,
   input  logic                     hilo_en,
   input  logic                     mfhi,
   input  logic                     mflo,
   output logic [WIDTH-1:0]         HI,
   output logic [WIDTH-1:0]         LO,
   output logic [WIDTH-1:0]         bus_out,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     pending
);

   fifo_entry_t      push_ent;
   fifo_entry_t      head_ent;
   logic             full;
   logic             empty;
   logic             commit;
   logic [WIDTH-1:0] head_hi;
   logic [WIDTH-1:0] head_lo;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             ovf_q, ovf_d;

   assign push_ent.product = res_product;
   assign push_ent.src     = res_src;

   result_fifo #(
      .DEPTH (DEPTH),
      .DW    ($bits(fifo_entry_t))
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (res_valid),
      .push_data_i (push_ent),
      .pop_i       (hilo_en),
      .head_o      (head_ent),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign res_ready = !full;
   assign pending   = !empty;
   assign commit    = hilo_en && !empty;
   assign head_hi   = head_ent.product[2*WIDTH-1:WIDTH];
   assign head_lo   = head_ent.product[WIDTH-1:0];

   // Overflow: upper half is not a pure sign extension of the lower half
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      ovf_d = ovf_q;
      if (commit) begin
         hi_d  = head_hi;
         lo_d  = head_lo;
         ovf_d = (head_ent.src == RES_SRC_MUL) &&
                 (head_hi != {WIDTH{head_lo[WIDTH-1]}});
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      if (mfhi)      bus_out = hi_q;
      else if (mflo) bus_out = lo_q;
      else           bus_out = '0;
   end

   assign HI  = hi_q;
   assign LO  = lo_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_hilo_writeback.sv
// Randomized bench for hilo_writeback against a queue-based model.
// Directed scenarios pin the model with literal expectations.
module tb_hilo_writeback;

   localparam int W = 32;
   localparam int D = 2;
   localparam longint MINV = -64'sd2147483648;
   localparam longint MAXV = 64'sd2147483647;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          res_valid = 1'b0;
   logic          res_ready;
   logic [63:0]   res_product = '0;
   logic          res_src = 1'b0;
   logic          hilo_en = 1'b0;
   logic          mfhi = 1'b0;
   logic          mflo = 1'b0;
   logic [W-1:0]  HI, LO, bus_out;
   logic          ovf;
   logic [1:0]    count;
   logic          pending;

   int            vecs = 0;
   int            errs = 0;
   bit            run_cmp = 1'b0;

   logic [64:0]   mq[$];
   logic [31:0]   m_hi = '0;
   logic [31:0]   m_lo = '0;
   logic          m_ovf = 1'b0;

   always #5 clk = ~clk;

   hilo_writeback #(.WIDTH(W), .DEPTH(D)) dut (
      .clk         (clk),
      .reset       (rst_n),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_product (res_product),
      .res_src     (res_src),
      .hilo_en     (hilo_en),
      .mfhi        (mfhi),
      .mflo        (mflo),
      .HI          (HI),
      .LO          (LO),
      .bus_out     (bus_out),
      .ovf         (ovf),
      .count       (count),
      .pending     (pending)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // A multiplier product overflows when it is outside the signed 32-bit range
   function automatic logic ovf_of(input logic [64:0] e);
      longint p;
      p = e[64:1];
      return (e[0] == 1'b0) && (p < MINV || p > MAXV);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_hi  = '0;
      m_lo  = '0;
      m_ovf = 1'b0;
   endtask

   task automatic model_update();
      bit          psh;
      bit          pop;
      logic [64:0] e;
      psh = res_valid && (mq.size() < D);
      pop = hilo_en && (mq.size() > 0);
      if (pop) begin
         e     = mq.pop_front();
         m_hi  = e[64:33];
         m_lo  = e[32:1];
         m_ovf = ovf_of(e);
      end
      if (psh) mq.push_back({res_product, res_src});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
   endtask

   task automatic drv(input logic v, input logic [63:0] p,
                      input logic s, input logic e);
      res_valid   = v;
      res_product = p;
      res_src     = s;
      hilo_en     = e;
   endtask

   function automatic logic [31:0] m_bus();
      if (mfhi)      return m_hi;
      else if (mflo) return m_lo;
      else           return '0;
   endfunction

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("HI", HI, m_hi);
         chk("LO", LO, m_lo);
         chk("ovf", ovf, m_ovf);
         chk("count", count, mq.size());
         chk("pending", pending, mq.size() != 0);
         chk("res_ready", res_ready, mq.size() != D);
         chk("bus_out", bus_out, m_bus());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] p;
      int          k;
      model_reset();
      run_cmp = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst HI", HI, 0);
      chk("rst count", count, 0);
      chk("rst ready", res_ready, 1);

      // small product, commit the next cycle
      drv(1, 64'h00000000_00000006, 0, 0); tick();
      drv(0, 0, 0, 1); tick();
      drv(0, 0, 0, 0);
      chk("t1 HI", HI, 0);
      chk("t1 LO", LO, 6);
      chk("t1 ovf", ovf, 0);
      chk("t1 pending", pending, 0);

      // negative product and read mux
      drv(1, 64'hFFFFFFFF_FFFFFFFA, 0, 0); tick();
      drv(0, 0, 0, 1); tick();
      drv(0, 0, 0, 0);
      chk("t2 HI", HI, 32'hFFFFFFFF);
      chk("t2 LO", LO, 32'hFFFFFFFA);
      chk("t2 ovf", ovf, 0);
      mfhi = 1; #1;
      chk("t2 mfhi", bus_out, 32'hFFFFFFFF);
      mflo = 1; #1;
      chk("t2 both", bus_out, 32'hFFFFFFFF);
      mfhi = 0; #1;
      chk("t2 mflo", bus_out, 32'hFFFFFFFA);
      mflo = 0; #1;
      chk("t2 none", bus_out, 0);

      // overflow for mul, none for div
      drv(1, 64'h00000001_00000000, 0, 0); tick();
      drv(0, 0, 0, 1); tick();
      drv(0, 0, 0, 0);
      chk("t3 HI", HI, 1);
      chk("t3 LO", LO, 0);
      chk("t3 ovf mul", ovf, 1);
      drv(1, 64'h00000001_00000000, 1, 0); tick();
      drv(0, 0, 0, 1); tick();
      drv(0, 0, 0, 0);
      chk("t3 ovf div", ovf, 0);

      // fill, backpressure, drain
      drv(1, 64'h1, 0, 0); tick();
      drv(1, 64'h2, 0, 0); tick();
      drv(1, 64'h3, 0, 0); tick();
      chk("t4 count", count, 2);
      chk("t4 ready", res_ready, 0);
      drv(1, 64'h3, 0, 1); tick();
      chk("t4 LO1", LO, 1);
      chk("t4 count1", count, 1);
      drv(1, 64'h3, 0, 1); tick();
      chk("t4 LO2", LO, 2);
      chk("t4 count2", count, 1);

      // simultaneous push/pop with one entry
      drv(1, 64'h4, 0, 1); tick();
      chk("t5 LO3", LO, 3);
      chk("t5 count", count, 1);
      drv(0, 0, 0, 1); tick();
      chk("t5 LO4", LO, 4);
      drv(0, 0, 0, 1); tick();
      chk("t5 empty LO", LO, 4);
      chk("t5 empty HI", HI, 0);

      // async reset with entries buffered
      drv(1, 64'h00000005_00000000, 0, 0); tick();
      drv(0, 0, 0, 1); tick();
      drv(1, 64'h7, 0, 0); tick();
      drv(1, 64'h8, 0, 0); tick();
      drv(0, 0, 0, 0);
      chk("t6 HI pre", HI, 5);
      chk("t6 count pre", count, 2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6 HI", HI, 0);
      chk("t6 LO", LO, 0);
      chk("t6 count", count, 0);
      chk("t6 pending", pending, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv(0, 0, 0, 1); tick();
      drv(0, 0, 0, 0);
      chk("t6 post HI", HI, 0);
      chk("t6 post LO", LO, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 3);
         case (k)
            0: p = {32'h0, 32'($urandom)};
            1: p = {32'hFFFFFFFF, 1'b1, 31'($urandom)};
            2: p = {32'($urandom), 32'($urandom)};
            default: p = {32'h0, 1'b1, 31'($urandom)};
         endcase
         drv(($urandom % 3) != 0, p, ($urandom % 4) == 0,
             ($urandom % 2) == 1);
         mfhi = 1'($urandom);
         mflo = 1'($urandom);
         if (i == 200) begin
            @(posedge clk);
            model_update();
            #3;
            rst_n = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      drv(0, 0, 0, 0);
      tick();
      run_cmp = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
